// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the sequential ALU.
//  - op_e    : operation codes. The low three bits of the legacy codes are kept so the existing
//              ALU-control decode carries over unchanged; bit 3 marks the iterative ops.
//  - state_e : control FSM states.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OpAnd  = 4'h0,
    OpOr   = 4'h1,
    OpAdd  = 4'h2,
    OpSllv = 4'h3,
    OpSrlv = 4'h4,
    OpSub  = 4'h6,
    OpSlt  = 4'h7,
    OpMulu = 4'h8,
    OpDivu = 4'h9
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StOne,
    StIter,
    StFin
  } state_e;

endpackage

// File: rtl/alu_seq_iter.sv
// alu_seq_iter: shared iterative engine for unsigned multiply (shift-add) and unsigned divide
// (restoring). One bit is processed per step through a single W+2-bit add/subtract.
// Ports:
//  clk, reset    clock, async active-high reset
//  load_i        capture a_i/b_i/mul_i and clear the step count
//  step_i        perform one iteration
//  mul_i         1 = multiply, 0 = divide (sampled on load)
//  a_i, b_i      multiplier/dividend and multiplicand/divisor
//  last_o        the step being taken now is the W-th one
//  lo_o, hi_o    low/high halves of the accumulator (product, or quotient/remainder)
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int unsigned W = 32,
  localparam int unsigned SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         step_i,
  input  logic         mul_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         last_o,
  output logic [W-1:0] lo_o,
  output logic [W-1:0] hi_o
);

  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   b_q, b_d;
  logic           mul_q, mul_d;
  logic [SHW:0]   cnt_q, cnt_d;

  logic [W-1:0]   acc_hi;
  logic [W:0]     x, addend;
  logic [W+1:0]   sum;
  logic           no_borrow;

  always_comb begin
    acc_hi = acc_q[2*W-1:W];
    // Multiply: upper half plus (optionally) the multiplicand.
    // Divide: partial remainder shifted left one bit, minus the divisor.
    x      = mul_q ? {1'b0, acc_hi} : {acc_hi, acc_q[W-1]};
    addend = mul_q ? {1'b0, (acc_q[0] ? b_q : {W{1'b0}})} : ~{1'b0, b_q};
    sum    = {1'b0, x} + {1'b0, addend} + {{(W+1){1'b0}}, ~mul_q};
    // For subtraction the top carry is set exactly when the remainder is >= divisor.
    no_borrow = sum[W+1];

    acc_d = acc_q;
    b_d   = b_q;
    mul_d = mul_q;
    cnt_d = cnt_q;
    if (load_i) begin
      acc_d = {{W{1'b0}}, a_i};
      b_d   = b_i;
      mul_d = mul_i;
      cnt_d = '0;
    end else if (step_i) begin
      cnt_d = cnt_q + (SHW + 1)'(1);
      if (mul_q) begin
        acc_d = {sum[W:0], acc_q[W-1:1]};
      end else begin
        acc_d = {(no_borrow ? sum[W-1:0] : x[W-1:0]), acc_q[W-2:0], no_borrow};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      b_q   <= '0;
      mul_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
      mul_q <= mul_d;
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == (SHW + 1)'(W - 1));
  assign lo_o   = acc_q[W-1:0];
  assign hi_o   = acc_q[2*W-1:W];

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU for the EX stage.
// Single-cycle ops (add/sub/slt/and/or/sllv/srlv) complete one cycle after acceptance;
// MULU and DIVU iterate one bit per cycle in alu_seq_iter and complete W+1 cycles after.
// Ports:
//  clk, reset    clock, async active-high reset
//  start         request; op/a/b sampled when start=1 and busy=0
//  op, a, b      operation code and operands (shift amount in a[SHW-1:0])
//  busy          high while an accepted operation is in flight (not in the done cycle)
//  done          one-cycle completion pulse
//  result, hi    sum/low product/quotient and high product/remainder (0 for other ops)
//  zout, nout    result == 0, result sign bit
//  dz            DIVU with b == 0
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned W = 32,
  localparam int unsigned SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic [W-1:0] hi,
  output logic         zout,
  output logic         nout,
  output logic         dz
);

  state_e       state_q, state_d;
  logic [3:0]   op_q, op_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [W-1:0] result_q, result_d, hi_q, hi_d;
  logic         busy_q, busy_d, done_q, done_d, dz_q, dz_d;

  logic         accept, iter_last;
  logic [W-1:0] iter_lo, iter_hi;
  logic [W-1:0] one_res, one_hi, diff;
  logic         one_dz;

  // Only IDLE accepts; busy mirrors every other state, so this matches start && !busy.
  assign accept = start && (state_q == StIdle);

  alu_seq_iter #(
    .W(W)
  ) u_iter (
    .clk    (clk),
    .reset  (reset),
    .load_i (accept),
    .step_i (state_q == StIter),
    .mul_i  (op == OpMulu),
    .a_i    (a),
    .b_i    (b),
    .last_o (iter_last),
    .lo_o   (iter_lo),
    .hi_o   (iter_hi)
  );

  // Single-cycle datapath, fed from the operands captured at acceptance.
  always_comb begin
    one_res = '0;
    one_hi  = '0;
    one_dz  = 1'b0;
    diff    = a_q - b_q;
    case (op_q)
      OpAdd:  one_res = a_q + b_q;
      OpSub:  one_res = a_q + ~b_q + W'(1);
      OpSlt:  one_res = {{(W-1){1'b0}}, diff[W-1]};
      OpAnd:  one_res = a_q & b_q;
      OpOr:   one_res = a_q | b_q;
      OpSllv: one_res = b_q << a_q[SHW-1:0];
      OpSrlv: one_res = b_q >> a_q[SHW-1:0];
      // Only divide-by-zero reaches the single-cycle path.
      OpDivu: begin
        one_res = '1;
        one_hi  = a_q;
        one_dz  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    hi_d     = hi_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          dz_d    = 1'b0;
          state_d = ((op == OpMulu) || ((op == OpDivu) && (b != '0))) ? StIter : StOne;
        end
      end
      StOne: begin
        result_d = one_res;
        hi_d     = one_hi;
        dz_d     = one_dz;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      StIter: begin
        if (iter_last) state_d = StFin;
      end
      StFin: begin
        result_d = iter_lo;
        hi_d     = iter_hi;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      hi_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign hi     = hi_q;
  assign dz     = dz_q;
  assign zout   = (result_q == '0);
  assign nout   = result_q[W-1];

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [3:0]   op;
  logic [W-1:0] a, b, result, hi;
  logic         busy, done, zout, nout, dz;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int overlap_cnt = 0;

  always #5 clk = ~clk;

  alu_seq #(
    .W(W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .hi     (hi),
    .zout   (zout),
    .nout   (nout),
    .dz     (dz)
  );

  // Passive monitor for done pulses and busy/done overlap.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) done_cnt <= done_cnt + 1;
      if (busy && done) overlap_cnt <= overlap_cnt + 1;
    end
  end

  // Reference model straight from the operation definitions.
  function automatic void model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic [W-1:0] h,
                                output logic z, output int l);
    logic [2*W-1:0] p;
    logic [W-1:0]   d;
    r = '0; h = '0; z = 1'b0; l = 1;
    d = x - y;
    case (o)
      4'h2: r = x + y;
      4'h6: r = x - y;
      4'h7: r = {{(W-1){1'b0}}, d[W-1]};
      4'h0: r = x & y;
      4'h1: r = x | y;
      4'h3: r = y << x[4:0];
      4'h4: r = y >> x[4:0];
      4'h8: begin
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        r = p[W-1:0]; h = p[2*W-1:W]; l = W + 1;
      end
      4'h9: begin
        if (y == 0) begin r = '1; h = x; z = 1'b1; end
        else begin r = x / y; h = x % y; l = W + 1; end
      end
      default: ;
    endcase
  endfunction

  // Called at a negedge; the next posedge is the accept edge (cycle 0).
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
  endtask

  // Returns the cycle (relative to the accept edge) of the done pulse, or -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, zout, nout, dz} !== 5'b00100) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 00100", {busy, done, zout, nout, dz});
    end
    vectors++;
    if ({result, hi} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got result=%h hi=%h want 0/0", result, hi);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_divu();
    int lat;
    issue(4'h2, 32'd5, 32'd6);
    wait_done(lat);
    vectors++;
    if (result !== 32'd11) begin
      miscompares++;
      $display("FAIL pre_reset_add: got %h want 0000000b", result);
    end
    @(negedge clk);
    issue(4'h9, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if ({busy, done, zout} !== 3'b001 || result !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_divu: got busy/done/zout=%b result=%h want 001/0",
               {busy, done, zout}, result);
    end
    @(negedge clk);
    reset = 1'b0;
    issue(4'h2, 32'd1, 32'd2);
    wait_done(lat);
    vectors++;
    if (lat !== 1 || result !== 32'd3) begin
      miscompares++;
      $display("FAIL after_reset_add: got lat=%0d result=%h want 1/00000003", lat, result);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    issue(4'h2, 32'h7FFF_FFFF, 32'h1);
    wait_done(lat);
    vectors++;
    if (lat !== 1 || result !== 32'h8000_0000 || nout !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_add: got lat=%0d result=%h nout=%b busy=%b want 1/80000000/1/0",
               lat, result, nout, busy);
    end
    issue(4'h6, 32'd3, 32'd5);
    wait_done(lat);
    vectors++;
    if (lat !== 1 || result !== 32'hFFFF_FFFE) begin
      miscompares++;
      $display("FAIL b2b_sub: got lat=%0d result=%h want 1/fffffffe", lat, result);
    end
    issue(4'h7, 32'd3, 32'd5);
    wait_done(lat);
    vectors++;
    if (lat !== 1 || result !== 32'd1 || hi !== '0) begin
      miscompares++;
      $display("FAIL b2b_slt: got lat=%0d result=%h hi=%h want 1/00000001/0", lat, result, hi);
    end
  endtask

  task automatic test_mulu();
    int lat;
    logic extra;
    @(negedge clk);
    issue(4'h8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      // Raised before edge 10 so that the DUT sees it at cycle 10.
      if (i == 10) begin start = 1'b1; op = 4'h2; a = 32'd1; b = 32'd1; end
      @(negedge clk);
      start = 1'b0;
      if (done) begin lat = i; break; end
    end
    vectors++;
    if (lat !== 33) begin
      miscompares++;
      $display("FAIL mulu_latency: got %0d want 33", lat);
    end
    vectors++;
    if (hi !== 32'hFFFF_FFFE || result !== 32'h1 || dz !== 1'b0) begin
      miscompares++;
      $display("FAIL mulu_value: got hi=%h result=%h dz=%b want fffffffe/00000001/0",
               hi, result, dz);
    end
    extra = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || busy) extra = 1'b1;
    end
    vectors++;
    if (extra !== 1'b0 || result !== 32'h1) begin
      miscompares++;
      $display("FAIL mulu_ignored_start: got activity=%b result=%h want 0/00000001",
               extra, result);
    end
  endtask

  task automatic test_divu();
    int lat;
    issue(4'h9, 32'd100, 32'd7);
    wait_done(lat);
    vectors++;
    if (lat !== 33 || result !== 32'd14 || hi !== 32'd2 || dz !== 1'b0) begin
      miscompares++;
      $display("FAIL divu_100_7: got lat=%0d result=%h hi=%h dz=%b want 33/0000000e/2/0",
               lat, result, hi, dz);
    end
    issue(4'h9, 32'h1234, 32'h0);
    wait_done(lat);
    vectors++;
    if (lat !== 1 || result !== 32'hFFFF_FFFF || hi !== 32'h1234 || dz !== 1'b1) begin
      miscompares++;
      $display("FAIL divu_by_zero: got lat=%0d result=%h hi=%h dz=%b want 1/ffffffff/1234/1",
               lat, result, hi, dz);
    end
  endtask

  task automatic test_shift_undef();
    int lat;
    issue(4'h3, 32'h3F, 32'h1);
    wait_done(lat);
    vectors++;
    if (result !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL sllv: got %h want 80000000", result);
    end
    issue(4'h4, 32'h1F, 32'h8000_0000);
    wait_done(lat);
    vectors++;
    if (result !== 32'h1) begin
      miscompares++;
      $display("FAIL srlv: got %h want 00000001", result);
    end
    issue(4'h9, 32'h55, 32'h0);
    wait_done(lat);
    issue(4'hF, 32'hDEAD, 32'hBEEF);
    wait_done(lat);
    vectors++;
    if (lat !== 1 || result !== '0 || hi !== '0 || zout !== 1'b1 || dz !== 1'b0) begin
      miscompares++;
      $display("FAIL undef_op: got lat=%0d result=%h hi=%h zout=%b dz=%b want 1/0/0/1/0",
               lat, result, hi, zout, dz);
    end
  endtask

  task automatic test_random();
    logic [3:0]   singles [7] = '{4'h2, 4'h6, 4'h7, 4'h0, 4'h1, 4'h3, 4'h4};
    logic [3:0]   o;
    logic [W-1:0] x, y, er, eh;
    logic         ed;
    int           el, lat, sel, base, issued;
    repeat (2) @(negedge clk);
    base   = done_cnt;
    issued = 0;
    for (int n = 0; n < 10000; n++) begin
      sel = $urandom_range(0, 19);
      if (sel == 0)      o = 4'h8;
      else if (sel == 1) o = 4'h9;
      else if (sel == 2) o = 4'($urandom_range(10, 15));
      else if (sel == 3) o = 4'h5;
      else               o = singles[sel % 7];
      x = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      y = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      if ($urandom_range(0, 7) == 0) y = '0;
      model(o, x, y, er, eh, ed, el);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(o, x, y);
      issued++;
      wait_done(lat);
      vectors++;
      if (lat !== el || result !== er || hi !== eh || zout !== (er == '0) ||
          nout !== er[W-1] || dz !== ed || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL random op=%h a=%h b=%h: got lat=%0d res=%h hi=%h z=%b n=%b dz=%b busy=%b want lat=%0d res=%h hi=%h dz=%b",
                 o, x, y, lat, result, hi, zout, nout, dz, busy, el, er, eh, ed);
      end
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (done_cnt - base !== issued) begin
      miscompares++;
      $display("FAIL done_count: got %0d want %0d", done_cnt - base, issued);
    end
    vectors++;
    if (overlap_cnt !== 0) begin
      miscompares++;
      $display("FAIL busy_done_overlap: got %0d want 0", overlap_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_divu();
    test_back_to_back();
    test_mulu();
    test_divu();
    test_shift_undef();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
